cpu65xx_alu_sequencer: RTL and testbench

- Drives the 65xx ALU from the execution side.
- Accepts ALU or relative-branch requests over a valid/ready handshake and sequences them over one or more cycles.
- Sets the ALU operation, operands and flag inputs each cycle; captures result and flags.
- Owns the processor status register P. Returns the result, or the branch target PC, on a one-cycle response strobe.

---
 rtl/cpu65xx_alu_sequencer_pkg.sv | 47 ++++
 rtl/cpu65xx_alu_sequencer_status_reg.sv | 44 ++++
 rtl/cpu65xx_alu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cpu65xx_alu_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu65xx_alu_sequencer_pkg.sv
// Shared constants for the 65xx ALU sequencer: ALU op/SOP codes, P bit positions,
// request kinds, reset value of P and sequencer state encodings (DEC_WAIT exists only with CPU65XX_CMOS_DECIMAL_CYCLE_EN).
package cpu65xx_alu_sequencer_pkg;

    localparam logic [3:0] ALU_OP_ADC   = 4'd0;
    localparam logic [3:0] ALU_OP_SBC   = 4'd1;
    localparam logic [3:0] ALU_OP_AND   = 4'd2;
    localparam logic [3:0] ALU_OP_ORA   = 4'd3;
    localparam logic [3:0] ALU_OP_EOR   = 4'd4;
    localparam logic [3:0] ALU_OP_CMP   = 4'd5;
    localparam logic [3:0] ALU_OP_SGL   = 4'd6;
    localparam logic [3:0] ALU_OP_ADD   = 4'd7;
    localparam logic [3:0] ALU_OP_FIXUP = 4'd8;

    localparam logic [2:0] ALU_SOP_TEST_N = 3'd0;
    localparam logic [2:0] ALU_SOP_TEST_V = 3'd1;
    localparam logic [2:0] ALU_SOP_TEST_Z = 3'd2;
    localparam logic [2:0] ALU_SOP_TEST_C = 3'd3;

    localparam int C_BIT_IN_P = 0;
    localparam int Z_BIT_IN_P = 1;
    localparam int D_BIT_IN_P = 3;
    localparam int V_BIT_IN_P = 6;
    localparam int N_BIT_IN_P = 7;

    localparam logic REQ_KIND_ALU    = 1'b0;
    localparam logic REQ_KIND_BRANCH = 1'b1;

    localparam logic [7:0] P_RESET_VALUE = 8'h24;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        BR_TEST = 3'd2,
        BR_ADD  = 3'd3,
        BR_FIX  = 3'd4
`ifdef CPU65XX_CMOS_DECIMAL_CYCLE_EN
        ,
        DEC_WAIT = 3'd5
`endif
    } seqState_e;

    function automatic logic isDecimalOp(input logic [3:0] op);
        return (op == ALU_OP_ADC) || (op == ALU_OP_SBC);
    endfunction

endpackage

// File: rtl/cpu65xx_alu_sequencer_status_reg.sv
// Processor status register P: external loads override ALU flag updates, bit 5 always reads 1.
module cpu65xx_status_reg
    import cpu65xx_alu_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pWrite_i,
    input  logic [7:0] pWriteData_i,
    input  logic       flagWrite_i,
    input  logic       negative_i,
    input  logic       zero_i,
    input  logic       carry_i,
    input  logic       overflow_i,
    output logic [7:0] p_o
);

    logic [7:0] p_q;
    logic [7:0] p_d;

    // An external load in the same cycle as an ALU flag update wins outright.
    always_comb begin
        p_d = p_q;
        if (pWrite_i) begin
            p_d = pWriteData_i;
        end else if (flagWrite_i) begin
            p_d[N_BIT_IN_P] = negative_i;
            p_d[V_BIT_IN_P] = overflow_i;
            p_d[Z_BIT_IN_P] = zero_i;
            p_d[C_BIT_IN_P] = carry_i;
        end
        p_d[5] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_q <= P_RESET_VALUE;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/cpu65xx_alu_sequencer.sv
// Sequences ALU operations and relative branches through the 65xx ALU and owns P.
// Define CPU65XX_CMOS_DECIMAL_CYCLE_EN to add the 65C02 extra cycle for decimal ADC/SBC.
module cpu65xx_alu_sequencer
    import cpu65xx_alu_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqKind,
    input  logic [3:0]  reqOperation,
    input  logic [2:0]  reqOpExtension,
    input  logic [7:0]  reqOperandA,
    input  logic [7:0]  reqOperandB,
    input  logic        reqUpdateFlags,
    input  logic        reqBranchOnSet,
    input  logic [15:0] reqPc,
    output logic [7:0]  aluOperandA,
    output logic [7:0]  aluOperandB,
    output logic        aluCarryIn,
    output logic        aluOverflowIn,
    output logic [3:0]  aluOperation,
    output logic [2:0]  aluOpExtension,
    output logic        aluDecimalMode,
    input  logic [7:0]  aluResult,
    input  logic        aluCarryOut,
    input  logic        aluZero,
    input  logic        aluNegative,
    input  logic        aluOverflowOut,
    input  logic        aluBranchCondition,
    output logic        rspValid,
    output logic [7:0]  rspResult,
    output logic [15:0] rspPc,
    output logic        rspTaken,
    output logic [7:0]  statusP,
    input  logic        pWrite,
    input  logic [7:0]  pWriteData
);

    seqState_e   state_q;
    logic [3:0]  op_q;
    logic [2:0]  ext_q;
    logic [7:0]  opA_q;
    logic [7:0]  opB_q;
    logic        upd_q;
    logic        onSet_q;
    logic [15:0] pc_q;
    logic        rspValid_q;
    logic [7:0]  rspResult_q;
    logic [15:0] rspPc_q;
    logic        rspTaken_q;
`ifdef CPU65XX_CMOS_DECIMAL_CYCLE_EN
    logic [7:0]  holdResult_q;
`endif

    cpu65xx_status_reg u_statusReg (
        .clk_i        (clk),
        .reset_i      (reset),
        .pWrite_i     (pWrite),
        .pWriteData_i (pWriteData),
        .flagWrite_i  ((state_q == EXEC) && upd_q),
        .negative_i   (aluNegative),
        .zero_i       (aluZero),
        .carry_i      (aluCarryOut),
        .overflow_i   (aluOverflowOut),
        .p_o          (statusP)
    );

    // ALU inputs are decoded from the current state and the registered request.
    always_comb begin
        aluOperation   = ALU_OP_SGL;
        aluOpExtension = 3'd0;
        aluOperandA    = 8'h00;
        aluOperandB    = 8'h00;
        unique case (state_q)
            EXEC: begin
                aluOperation   = op_q;
                aluOpExtension = ext_q;
                aluOperandA    = opA_q;
                aluOperandB    = opB_q;
            end
            BR_TEST: begin
                aluOpExtension = ext_q;
                aluOperandA    = statusP;
            end
            BR_ADD: begin
                aluOperation = ALU_OP_ADD;
                aluOperandA  = pc_q[7:0];
                aluOperandB  = opB_q;
            end
            BR_FIX: begin
                aluOperation = ALU_OP_FIXUP;
                aluOperandA  = pc_q[15:8];
                aluOperandB  = opB_q;
            end
            default: ;
        endcase
    end

    assign aluCarryIn     = statusP[C_BIT_IN_P];
    assign aluOverflowIn  = statusP[V_BIT_IN_P];
    assign aluDecimalMode = statusP[D_BIT_IN_P] && isDecimalOp(aluOperation);
    assign reqReady       = (state_q == IDLE);

    // Page cross in BR_ADD: carry out disagrees with the sign of the offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            ext_q       <= 3'd0;
            opA_q       <= 8'h00;
            opB_q       <= 8'h00;
            upd_q       <= 1'b0;
            onSet_q     <= 1'b0;
            pc_q        <= 16'h0000;
            rspValid_q  <= 1'b0;
            rspResult_q <= 8'h00;
            rspPc_q     <= 16'h0000;
            rspTaken_q  <= 1'b0;
`ifdef CPU65XX_CMOS_DECIMAL_CYCLE_EN
            holdResult_q <= 8'h00;
`endif
        end else begin
            rspValid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        op_q    <= reqOperation;
                        ext_q   <= reqOpExtension;
                        opA_q   <= reqOperandA;
                        opB_q   <= reqOperandB;
                        upd_q   <= reqUpdateFlags;
                        onSet_q <= reqBranchOnSet;
                        pc_q    <= reqPc;
                        state_q <= (reqKind == REQ_KIND_BRANCH) ? BR_TEST : EXEC;
                    end
                end
                EXEC: begin
`ifdef CPU65XX_CMOS_DECIMAL_CYCLE_EN
                    if (isDecimalOp(op_q) && statusP[D_BIT_IN_P]) begin
                        holdResult_q <= aluResult;
                        state_q      <= DEC_WAIT;
                    end else begin
                        rspValid_q  <= 1'b1;
                        rspResult_q <= aluResult;
                        state_q     <= IDLE;
                    end
`else
                    rspValid_q  <= 1'b1;
                    rspResult_q <= aluResult;
                    state_q     <= IDLE;
`endif
                end
`ifdef CPU65XX_CMOS_DECIMAL_CYCLE_EN
                DEC_WAIT: begin
                    rspValid_q  <= 1'b1;
                    rspResult_q <= holdResult_q;
                    state_q     <= IDLE;
                end
`endif
                BR_TEST: begin
                    if (aluBranchCondition == onSet_q) begin
                        state_q <= BR_ADD;
                    end else begin
                        rspValid_q <= 1'b1;
                        rspPc_q    <= pc_q;
                        rspTaken_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                BR_ADD: begin
                    pc_q[7:0] <= aluResult;
                    if (aluBranchCondition ^ opB_q[7]) begin
                        state_q <= BR_FIX;
                    end else begin
                        rspValid_q <= 1'b1;
                        rspPc_q    <= {pc_q[15:8], aluResult};
                        rspTaken_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                BR_FIX: begin
                    rspValid_q <= 1'b1;
                    rspPc_q    <= {aluResult, pc_q[7:0]};
                    rspTaken_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rspValid  = rspValid_q;
    assign rspResult = rspResult_q;
    assign rspPc     = rspPc_q;
    assign rspTaken  = rspTaken_q;

endmodule

// File: tb/tb_cpu65xx_alu_sequencer.sv
// Scoreboard bench for cpu65xx_alu_sequencer with a small behavioural 65xx ALU attached.
module tb_cpu65xx_alu_sequencer;
    import cpu65xx_alu_sequencer_pkg::*;

`ifdef CPU65XX_CMOS_DECIMAL_CYCLE_EN
    localparam int DEC_LAT = 3;
`else
    localparam int DEC_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqKind = 1'b0;
    logic [3:0]  reqOperation = 4'd0;
    logic [2:0]  reqOpExtension = 3'd0;
    logic [7:0]  reqOperandA = 8'h00;
    logic [7:0]  reqOperandB = 8'h00;
    logic        reqUpdateFlags = 1'b0;
    logic        reqBranchOnSet = 1'b0;
    logic [15:0] reqPc = 16'h0000;
    logic [7:0]  aluOperandA, aluOperandB;
    logic        aluCarryIn, aluOverflowIn;
    logic [3:0]  aluOperation;
    logic [2:0]  aluOpExtension;
    logic        aluDecimalMode;
    logic [7:0]  aluResult;
    logic        aluCarryOut, aluZero, aluNegative, aluOverflowOut, aluBranchCondition;
    logic        rspValid;
    logic [7:0]  rspResult;
    logic [15:0] rspPc;
    logic        rspTaken;
    logic [7:0]  statusP;
    logic        pWrite = 1'b0;
    logic [7:0]  pWriteData = 8'h00;

    typedef struct {
        string       name;
        logic        isBranch;
        logic [7:0]  res;
        logic [15:0] pc;
        logic        taken;
        logic [7:0]  p;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic watchDec = 1'b0;
    logic decSeen = 1'b0;

    cpu65xx_alu_sequencer dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqKind(reqKind),
        .reqOperation(reqOperation), .reqOpExtension(reqOpExtension),
        .reqOperandA(reqOperandA), .reqOperandB(reqOperandB),
        .reqUpdateFlags(reqUpdateFlags), .reqBranchOnSet(reqBranchOnSet), .reqPc(reqPc),
        .aluOperandA(aluOperandA), .aluOperandB(aluOperandB),
        .aluCarryIn(aluCarryIn), .aluOverflowIn(aluOverflowIn),
        .aluOperation(aluOperation), .aluOpExtension(aluOpExtension),
        .aluDecimalMode(aluDecimalMode), .aluResult(aluResult),
        .aluCarryOut(aluCarryOut), .aluZero(aluZero), .aluNegative(aluNegative),
        .aluOverflowOut(aluOverflowOut), .aluBranchCondition(aluBranchCondition),
        .rspValid(rspValid), .rspResult(rspResult), .rspPc(rspPc), .rspTaken(rspTaken),
        .statusP(statusP), .pWrite(pWrite), .pWriteData(pWriteData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: decimal ADC here reports V=0 and takes N/Z from the BCD result.
    logic [8:0] sum9;
    logic [4:0] lo, hi;
    always_comb begin
        sum9 = 9'd0;
        lo = 5'd0;
        hi = 5'd0;
        aluResult = 8'h00;
        aluCarryOut = 1'b0;
        aluOverflowOut = aluOverflowIn;
        aluBranchCondition = 1'b0;
        case (aluOperation)
            ALU_OP_ADC: begin
                if (aluDecimalMode) begin
                    lo = {1'b0, aluOperandA[3:0]} + {1'b0, aluOperandB[3:0]} + {4'd0, aluCarryIn};
                    if (lo > 5'd9) lo = lo + 5'd6;
                    hi = {1'b0, aluOperandA[7:4]} + {1'b0, aluOperandB[7:4]} + {4'd0, lo[4]};
                    if (hi > 5'd9) hi = hi + 5'd6;
                    aluResult = {hi[3:0], lo[3:0]};
                    aluCarryOut = hi[4];
                    aluOverflowOut = 1'b0;
                end else begin
                    sum9 = {1'b0, aluOperandA} + {1'b0, aluOperandB} + {8'd0, aluCarryIn};
                    aluResult = sum9[7:0];
                    aluCarryOut = sum9[8];
                    aluOverflowOut = (aluOperandA[7] == aluOperandB[7]) && (sum9[7] != aluOperandA[7]);
                end
            end
            ALU_OP_SBC: begin
                sum9 = {1'b0, aluOperandA} + {1'b0, ~aluOperandB} + {8'd0, aluCarryIn};
                aluResult = sum9[7:0];
                aluCarryOut = sum9[8];
                aluOverflowOut = (aluOperandA[7] != aluOperandB[7]) && (sum9[7] != aluOperandA[7]);
            end
            ALU_OP_CMP: begin
                aluResult = aluOperandA - aluOperandB;
                aluCarryOut = (aluOperandA >= aluOperandB);
            end
            ALU_OP_SGL: begin
                case (aluOpExtension)
                    ALU_SOP_TEST_N: aluBranchCondition = aluOperandA[7];
                    ALU_SOP_TEST_V: aluBranchCondition = aluOperandA[6];
                    ALU_SOP_TEST_Z: aluBranchCondition = aluOperandA[1];
                    ALU_SOP_TEST_C: aluBranchCondition = aluOperandA[0];
                    default:        aluBranchCondition = 1'b0;
                endcase
            end
            ALU_OP_ADD: begin
                sum9 = {1'b0, aluOperandA} + {1'b0, aluOperandB};
                aluResult = sum9[7:0];
                aluCarryOut = sum9[8];
                aluBranchCondition = sum9[8];
            end
            ALU_OP_FIXUP: aluResult = aluOperandB[7] ? aluOperandA - 8'd1 : aluOperandA + 8'd1;
            default: ;
        endcase
        aluZero = (aluResult == 8'h00);
        aluNegative = aluResult[7];
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mkExp(input string name, input logic isBranch, input logic [7:0] res,
                                   input logic [15:0] pc, input logic taken, input logic [7:0] p);
        exp_t e;
        e.name = name;
        e.isBranch = isBranch;
        e.res = res;
        e.pc = pc;
        e.taken = taken;
        e.p = p;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (watchDec && aluDecimalMode) decSeen = 1'b1;
        if (rspValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, ".cycle"}, 16'(cyc), 16'(e.cyc));
                checkOutput({e.name, ".statusP"}, {8'h00, statusP}, {8'h00, e.p});
                if (e.isBranch) begin
                    checkOutput({e.name, ".rspPc"}, rspPc, e.pc);
                    checkOutput({e.name, ".rspTaken"}, {15'd0, rspTaken}, {15'd0, e.taken});
                end else begin
                    checkOutput({e.name, ".rspResult"}, {8'h00, rspResult}, {8'h00, e.res});
                end
            end
        end
    end

    task automatic setP(input logic [7:0] value);
        @(posedge clk); #1;
        pWrite = 1'b1;
        pWriteData = value;
        @(posedge clk); #1;
        pWrite = 1'b0;
        @(negedge clk);
        checkOutput("pLoad", {8'h00, statusP}, {8'h00, value | 8'h20});
    endtask

    task automatic applyStimulus(input logic kind, input logic [3:0] op, input logic [2:0] ext,
                                 input logic [7:0] a, input logic [7:0] b, input logic upd,
                                 input logic onSet, input logic [15:0] pc, input int lat,
                                 input logic track, input logic collide, input exp_t e);
        int guard = 0;
        @(posedge clk); #1;
        reqKind = kind;
        reqOperation = op;
        reqOpExtension = ext;
        reqOperandA = a;
        reqOperandB = b;
        reqUpdateFlags = upd;
        reqBranchOnSet = onSet;
        reqPc = pc;
        reqValid = 1'b1;
        @(negedge clk);
        while (!reqReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!reqReady) checkOutput({e.name, ".acceptTimeout"}, 16'd0, 16'd1);
        e.cyc = cyc + lat;
        if (track) expQ.push_back(e);
        @(posedge clk); #1;
        reqValid = 1'b0;
        if (collide) begin
            pWrite = 1'b1;
            pWriteData = 8'h00;
            @(posedge clk); #1;
            pWrite = 1'b0;
        end
    endtask

    task automatic waitDone();
        int guard = 0;
        while (expQ.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) begin
            checkOutput("rspTimeout", 16'(expQ.size()), 16'd0);
            expQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.reqReady", {15'd0, reqReady}, 16'd1);
        checkOutput("reset.statusP", {8'h00, statusP}, 16'h0024);
        checkOutput("reset.rspValid", {15'd0, rspValid}, 16'd0);
        checkOutput("reset.rspResult", {8'h00, rspResult}, 16'h0000);
        checkOutput("reset.rspPc", rspPc, 16'h0000);
        checkOutput("reset.rspTaken", {15'd0, rspTaken}, 16'd0);

        setP(8'h2D);
        applyStimulus(REQ_KIND_ALU, ALU_OP_ADC, 3'd0, 8'h58, 8'h46, 1'b1, 1'b0, 16'h0, DEC_LAT, 1'b1, 1'b0,
                      mkExp("adcDecimal", 1'b0, 8'h05, 16'h0, 1'b0, 8'h2D));
        waitDone();

        setP(8'h24);
        applyStimulus(REQ_KIND_ALU, ALU_OP_ADC, 3'd0, 8'h50, 8'h50, 1'b1, 1'b0, 16'h0, 2, 1'b1, 1'b0,
                      mkExp("adcBinary", 1'b0, 8'hA0, 16'h0, 1'b0, 8'hE4));
        waitDone();

        setP(8'h26);
        applyStimulus(REQ_KIND_ALU, ALU_OP_ADC, 3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 16'h0, 2, 1'b1, 1'b0,
                      mkExp("adcNoFlags", 1'b0, 8'hA0, 16'h0, 1'b0, 8'h26));
        waitDone();

        setP(8'h24);
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_Z, 8'h00, 8'h10, 1'b0, 1'b1, 16'h1234, 2, 1'b1, 1'b0,
                      mkExp("beqNotTaken", 1'b1, 8'h00, 16'h1234, 1'b0, 8'h24));
        waitDone();

        setP(8'h2E);
        decSeen = 1'b0;
        watchDec = 1'b1;
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_Z, 8'h00, 8'h10, 1'b0, 1'b1, 16'h1234, 3, 1'b1, 1'b0,
                      mkExp("beqTaken", 1'b1, 8'h00, 16'h1244, 1'b1, 8'h2E));
        waitDone();
        watchDec = 1'b0;
        checkOutput("branchDecimalMode", {15'd0, decSeen}, 16'd0);

        setP(8'h24);
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_Z, 8'h00, 8'hF0, 1'b0, 1'b0, 16'h1205, 4, 1'b1, 1'b0,
                      mkExp("bneCrossDown", 1'b1, 8'h00, 16'h11F5, 1'b1, 8'h24));
        waitDone();
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_Z, 8'h00, 8'h10, 1'b0, 1'b0, 16'h12F8, 4, 1'b1, 1'b0,
                      mkExp("bneCrossUp", 1'b1, 8'h00, 16'h1308, 1'b1, 8'h24));
        waitDone();

        setP(8'h25);
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_C, 8'h00, 8'h05, 1'b0, 1'b0, 16'h2000, 2, 1'b1, 1'b0,
                      mkExp("bccNotTaken", 1'b1, 8'h00, 16'h2000, 1'b0, 8'h25));
        waitDone();

        setP(8'hA4);
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_N, 8'h00, 8'hFE, 1'b0, 1'b1, 16'h3050, 3, 1'b1, 1'b0,
                      mkExp("bmiBackSamePage", 1'b1, 8'h00, 16'h304E, 1'b1, 8'hA4));
        waitDone();

        setP(8'h24);
        applyStimulus(REQ_KIND_ALU, ALU_OP_CMP, 3'd0, 8'h10, 8'h10, 1'b1, 1'b0, 16'h0, 2, 1'b1, 1'b1,
                      mkExp("cmpCollision", 1'b0, 8'h00, 16'h0, 1'b0, 8'h20));
        waitDone();
        applyStimulus(REQ_KIND_ALU, ALU_OP_CMP, 3'd0, 8'h10, 8'h20, 1'b1, 1'b0, 16'h0, 2, 1'b1, 1'b0,
                      mkExp("cmpLess", 1'b0, 8'hF0, 16'h0, 1'b0, 8'hA0));
        waitDone();

        // Abort a page-crossing branch while it sits in BR_FIX.
        setP(8'h25);
        applyStimulus(REQ_KIND_BRANCH, 4'd0, ALU_SOP_TEST_Z, 8'h00, 8'hF0, 1'b0, 1'b0, 16'h1205, 4, 1'b0, 1'b0,
                      mkExp("abortedBranch", 1'b1, 8'h00, 16'h0, 1'b0, 8'h25));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midReset.rspValid", {15'd0, rspValid}, 16'd0);
        checkOutput("midReset.reqReady", {15'd0, reqReady}, 16'd1);
        checkOutput("midReset.statusP", {8'h00, statusP}, 16'h0024);
        checkOutput("midReset.rspPc", rspPc, 16'h0000);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
